// File: rtl/clk_div_ctrl.sv
// ---------------------------------------------------------------------------
// clk_div_ctrl
//   Sequencer that owns the ratio, reset and output-gate inputs of a clk_div
//   instance and changes the divide ratio without glitches on the gated clock.
//   A change runs: gate the output (GATE), hold the divider in reset while the
//   new ratio is loaded (HOLD), let the divider run ungated for
//   SETTLE_MULT*ratio cycles (SETTLE), then ungate (IDLE).
//
// Ports
//   clk_i        in   source clock, same clock that feeds clk_div
//   rst_i        in   synchronous reset, active-high
//   req_valid_i  in   new-ratio request valid
//   req_div_i    in   requested ratio, sampled only at the accept edge
//   req_ready_o  out  high only in IDLE, and low in the cycle done_o pulses
//   div_o        out  ratio to clk_div div_i
//   div_rst_no   out  to clk_div arst_ni; low holds the divider in reset
//   clk_en_o     out  enable for the downstream gate on the divided clock
//   busy_o       out  high in every state other than IDLE
//   done_o       out  1-cycle pulse: ratio change finished, or same-ratio no-op
//   err_o        out  1-cycle pulse: request rejected because ratio is 0
//   dbg_state_o  out  current FSM state (IDLE=0 RESP=1 GATE=2 HOLD=3 SETTLE=4)
//
// Handshake: a request is taken at a rising clk_i edge where req_valid_i and
// req_ready_o are both high. Valid while ready is low is ignored (not queued),
// and the requester may change or drop req_div_i freely after that edge.
// ---------------------------------------------------------------------------
module clk_div_ctrl #(
  parameter int DIV_WIDTH   = 4,
  parameter int DEFAULT_DIV = 1,
  parameter int GATE_CYCLES = 2,
  parameter int RST_CYCLES  = 2,
  parameter int SETTLE_MULT = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  input  logic [DIV_WIDTH-1:0] req_div_i,
  output logic                 req_ready_o,
  output logic [DIV_WIDTH-1:0] div_o,
  output logic                 div_rst_no,
  output logic                 clk_en_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [2:0]           dbg_state_o
);

  // Wide enough for SETTLE_MULT*(2**DIV_WIDTH-1) without wrapping.
  localparam int CNT_W = DIV_WIDTH + $clog2(SETTLE_MULT) + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RESP   = 3'd1,
    S_GATE   = 3'd2,
    S_HOLD   = 3'd3,
    S_SETTLE = 3'd4
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [DIV_WIDTH-1:0] r_req_div, w_req_div_nxt;
  logic                 r_from_req, w_from_req_nxt;
  logic [DIV_WIDTH-1:0] r_div, w_div_nxt;
  logic                 r_rst_n, w_rst_n_nxt;
  logic                 r_en, w_en_nxt;
  logic                 r_ready, w_ready_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_done, w_done_nxt;
  logic                 r_err, w_err_nxt;

  logic                 w_accept;
  logic [CNT_W-1:0]     w_settle_len;
  logic                 w_gate_last;
  logic                 w_hold_last;
  logic                 w_settle_last;

  assign w_accept      = (r_state == S_IDLE) && r_ready && req_valid_i;
  assign w_settle_len  = CNT_W'(SETTLE_MULT) * CNT_W'(r_div);
  assign w_gate_last   = (r_cnt == CNT_W'(GATE_CYCLES - 1));
  assign w_hold_last   = (r_cnt == CNT_W'(RST_CYCLES - 1));
  assign w_settle_last = (r_cnt == (w_settle_len - CNT_W'(1)));

  // Next state plus the registered value every output takes in that state.
  always_comb begin
    w_state_nxt    = r_state;
    w_req_div_nxt  = r_req_div;
    w_from_req_nxt = r_from_req;
    w_div_nxt      = r_div;
    w_done_nxt     = 1'b0;
    w_err_nxt      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_req_div_nxt = req_div_i;
          if (req_div_i == '0) begin
            w_state_nxt = S_RESP;
            w_err_nxt   = 1'b1;
          end else if (req_div_i == r_div) begin
            w_state_nxt = S_RESP;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt    = S_GATE;
            w_from_req_nxt = 1'b1;
          end
        end
      end
      S_RESP: w_state_nxt = S_IDLE;
      S_GATE: begin
        if (w_gate_last) begin
          w_state_nxt = S_HOLD;
          // Ratio changes on the same edge the divider enters reset.
          w_div_nxt   = r_req_div;
        end
      end
      S_HOLD: begin
        if (w_hold_last) w_state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (w_settle_last) begin
          w_state_nxt    = S_IDLE;
          // The post-reset settle ends silently; only a requested change reports.
          w_done_nxt     = r_from_req;
          w_from_req_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_HOLD;
    endcase

    // Counter restarts at zero on every state entry and only runs in timed states.
    if (w_state_nxt != r_state) begin
      w_cnt_nxt = '0;
    end else if (r_state == S_GATE || r_state == S_HOLD || r_state == S_SETTLE) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end else begin
      w_cnt_nxt = '0;
    end

    // Gate is open only in IDLE/RESP, both of which have the divider out of reset.
    w_en_nxt    = (w_state_nxt == S_IDLE) || (w_state_nxt == S_RESP);
    w_rst_n_nxt = (w_state_nxt != S_HOLD);
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    // No new request in the cycle a completion pulse is on the wire.
    w_ready_nxt = (w_state_nxt == S_IDLE) && !w_done_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_HOLD;
      r_cnt      <= '0;
      r_req_div  <= '0;
      r_from_req <= 1'b0;
      r_div      <= DIV_WIDTH'(DEFAULT_DIV);
      r_rst_n    <= 1'b0;
      r_en       <= 1'b0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_req_div  <= w_req_div_nxt;
      r_from_req <= w_from_req_nxt;
      r_div      <= w_div_nxt;
      r_rst_n    <= w_rst_n_nxt;
      r_en       <= w_en_nxt;
      r_ready    <= w_ready_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign req_ready_o = r_ready;
  assign div_o       = r_div;
  assign div_rst_no  = r_rst_n;
  assign clk_en_o    = r_en;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign err_o       = r_err;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clk_div_ctrl
//   Self-checking bench for clk_div_ctrl. The reference model is a timeline:
//   every accepted request or reset sets the cycle windows in which each
//   output is expected low/high, computed from the sequence lengths. Pulses
//   (done/err) go through an expected queue popped by the monitor. A small
//   behavioural divider driven by div_o/div_rst_no lets the monitor measure
//   the gated output period against the expected ratio.
// ---------------------------------------------------------------------------
module tb_clk_div_ctrl;

  localparam int DW  = 4;
  localparam int DEF = 1;
  localparam int G   = 2;
  localparam int R   = 2;
  localparam int SM  = 2;

  // ---------------- clock / reset / DUT ----------------
  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          req_valid_i = 1'b0;
  logic [DW-1:0] req_div_i = '0;
  logic          req_ready_o;
  logic [DW-1:0] div_o;
  logic          div_rst_no;
  logic          clk_en_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic [2:0]    dbg_state_o;

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  clk_div_ctrl #(
    .DIV_WIDTH  (DW),
    .DEFAULT_DIV(DEF),
    .GATE_CYCLES(G),
    .RST_CYCLES (R),
    .SETTLE_MULT(SM)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_valid_i(req_valid_i),
    .req_div_i  (req_div_i),
    .req_ready_o(req_ready_o),
    .div_o      (div_o),
    .div_rst_no (div_rst_no),
    .clk_en_o   (clk_en_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- reference model (cycle windows) ----------------
  // All cycle numbers are "sample cycles": the value seen at the falling edge
  // after rising edge number c.
  bit            m_on = 1'b0;
  int            m_chk_from = 0;
  int            m_lo = 0;
  int            m_en_hi = -1;
  int            m_rstn_lo = 0;
  int            m_rstn_hi = -1;
  int            m_busy_hi = -1;
  int            m_ready_from = 0;
  int            m_div_sw = 0;
  logic [DW-1:0] m_div_old = DW'(DEF);
  logic [DW-1:0] m_div_new = DW'(DEF);

  function automatic logic exp_ready(int c);
    return !(c >= m_lo && c < m_ready_from);
  endfunction
  function automatic logic exp_busy(int c);
    return (c >= m_lo && c <= m_busy_hi);
  endfunction
  function automatic logic exp_en(int c);
    return !(c >= m_lo && c <= m_en_hi);
  endfunction
  function automatic logic exp_rstn(int c);
    return !(c >= m_rstn_lo && c <= m_rstn_hi);
  endfunction
  function automatic logic [DW-1:0] exp_div(int c);
    return (c >= m_div_sw) ? m_div_new : m_div_old;
  endfunction

  // ---------------- scoreboard ----------------
  // entry = {kind {done,err}, sample cycle, div_o during the pulse}
  logic [21:0] exp_q[$];
  logic [21:0] sb_e;
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Behavioural clk_div: counts 0..div-1 while out of reset, tick on count 0.
  logic [DW-1:0] dcnt = '0;
  int last_tick = -1;
  always @(posedge clk_i) begin
    if (div_rst_no !== 1'b1) dcnt <= '0;
    else if (({1'b0, dcnt} + 5'd1) >= {1'b0, div_o}) dcnt <= '0;
    else dcnt <= dcnt + 1'b1;
  end

  // ---------------- monitor ----------------
  always @(negedge clk_i) begin
    if (m_on && cyc >= m_chk_from) begin
      chk("ready", 32'(req_ready_o), 32'(exp_ready(cyc)));
      chk("busy", 32'(busy_o), 32'(exp_busy(cyc)));
      chk("clk_en", 32'(clk_en_o), 32'(exp_en(cyc)));
      chk("div_rst_n", 32'(div_rst_no), 32'(exp_rstn(cyc)));
      chk("div", 32'(div_o), 32'(exp_div(cyc)));

      if (done_o !== 1'b0 || err_o !== 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", 32'({done_o, err_o}), 32'd0);
        end else begin
          sb_e = exp_q.pop_front();
          chk("pulse_kind", 32'({done_o, err_o}), 32'(sb_e[21:20]));
          chk("pulse_cycle", 32'(cyc), 32'(sb_e[19:4]));
          chk("pulse_div", 32'(div_o), 32'(sb_e[3:0]));
        end
      end else if (exp_q.size() > 0 && int'(exp_q[0][19:4]) < cyc) begin
        chk("missing_pulse", 32'(cyc), 32'(exp_q[0][19:4]));
        void'(exp_q.pop_front());
      end

      // Period of the gated divided clock, measured only across open-gate stretches.
      if (clk_en_o !== 1'b1) begin
        last_tick = -1;
      end else if (dcnt == '0) begin
        if (last_tick >= 0) chk("period", 32'(cyc - last_tick), 32'(exp_div(cyc)));
        last_tick = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk_i);
    #1;
  endtask

  task automatic do_reset(input int n);
    int lo;
    int r;
    step();
    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    lo = cyc + 1;
    r  = cyc + n;
    m_div_old    = exp_div(lo - 1);
    m_div_new    = DW'(DEF);
    m_div_sw     = lo;
    m_lo         = lo;
    m_en_hi      = r + R + SM * DEF - 1;
    m_busy_hi    = r + R + SM * DEF - 1;
    m_ready_from = r + R + SM * DEF;
    m_rstn_lo    = lo;
    m_rstn_hi    = r + R - 1;
    exp_q.delete();
    if (!m_on) begin
      m_on       = 1'b1;
      m_chk_from = lo;
    end
    repeat (n) step();
    rst_i = 1'b0;
  endtask

  // Model update for a request accepted at rising edge k.
  task automatic model_accept(input logic [DW-1:0] v, input int k);
    logic [DW-1:0] cur;
    int nn;
    cur = exp_div(k);
    m_lo = k;
    if (v == '0 || v == cur) begin
      exp_q.push_back({(v == '0) ? 2'b01 : 2'b10, 16'(k), cur});
      m_busy_hi    = k;
      m_ready_from = k + 1;
      m_en_hi      = k - 1;
      m_rstn_lo    = k;
      m_rstn_hi    = k - 1;
      m_div_old    = cur;
      m_div_new    = cur;
      m_div_sw     = k;
    end else begin
      nn = G + R + SM * int'(v) + 1;
      exp_q.push_back({2'b10, 16'(k + nn - 1), v});
      m_busy_hi    = k + nn - 2;
      m_ready_from = k + nn;
      m_en_hi      = k + nn - 2;
      m_rstn_lo    = k + G;
      m_rstn_hi    = k + G + R - 1;
      m_div_old    = cur;
      m_div_new    = v;
      m_div_sw     = k + G;
    end
  endtask

  task automatic request(input logic [DW-1:0] v);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      step();
      req_valid_i = 1'b1;
      req_div_i   = v;
      if (exp_ready(cyc)) begin
        model_accept(v, cyc + 1);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("request_timeout", 32'(cyc), 32'(m_ready_from));
    // Scramble the data bus after the accept edge; it must have no effect.
    step();
    req_valid_i = 1'b0;
    req_div_i   = DW'($urandom_range(0, 15));
  endtask

  // Idle cycles; while the model says not ready, throw random valid/data at it.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if (!exp_ready(cyc)) begin
        req_valid_i = 1'($urandom_range(0, 1));
        req_div_i   = DW'($urandom_range(0, 15));
      end else begin
        req_valid_i = 1'b0;
      end
    end
    req_valid_i = 1'b0;
  endtask

  task automatic wait_ready();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      step();
      req_valid_i = 1'b0;
      if (exp_ready(cyc)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("ready_timeout", 32'(cyc), 32'(m_ready_from));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] rv;
    do_reset(3);
    wait_ready();
    idle(4);

    request(4'd3);  wait_ready(); idle(8);
    request(4'd15); wait_ready(); idle(34);
    request(4'd0);  wait_ready(); idle(3);
    request(4'd3);  wait_ready(); idle(2);
    request(4'd3);  wait_ready(); idle(8);

    // Abort a change to 5 while it is settling.
    request(4'd5);
    repeat (6) step();
    do_reset(2);
    wait_ready();
    idle(4);

    for (int v = 1; v <= 15; v++) begin
      request(DW'(v));
      wait_ready();
      idle(2 * v + 2);
    end

    for (int i = 0; i < 40; i++) begin
      rv = ($urandom_range(0, 7) == 0) ? m_div_new : DW'($urandom_range(0, 15));
      request(rv);
      wait_ready();
      idle($urandom_range(0, 20));
    end

    idle(40);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog at cycle %0d: got timeout expected finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
